// File: rtl/add_pulse_gen_if.sv
// Burst request / add-pulse bundle between a control sequencer (master)
// and the add pulse generator (slave).
interface add_pulse_gen_if #(
   parameter int Bits    = 8,
   parameter int GapBits = 4
);
   logic               req_valid;
   logic               req_ready;
   logic [Bits-1:0]    req_count;
   logic [GapBits-1:0] req_gap;
   logic               abort;
   logic               add;
   logic               busy;
   logic [Bits-1:0]    remaining;
   logic               done;

   modport master (
      output req_valid,
      output req_count,
      output req_gap,
      output abort,
      input  req_ready,
      input  add,
      input  busy,
      input  remaining,
      input  done
   );

   modport slave (
      input  req_valid,
      input  req_count,
      input  req_gap,
      input  abort,
      output req_ready,
      output add,
      output busy,
      output remaining,
      output done
   );
endinterface

// File: rtl/add_pulse_gen.sv
// Emits a burst of one-cycle add pulses separated by a programmable idle gap,
// followed by a one-cycle done strobe unless the burst was aborted.
module add_pulse_gen #(
   parameter int Bits    = 8,
   parameter int GapBits = 4
) (
   input  logic          clk,
   input  logic          reset,
   add_pulse_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state;
   logic [Bits-1:0]    remaining;
   logic [GapBits-1:0] gap_len;
   logic [GapBits-1:0] gap_cnt;
   logic               done;
   logic               accept;

   assign bus.req_ready = (state == IDLE) && !reset;
   assign accept        = bus.req_valid && bus.req_ready;

   assign bus.add       = (state == PULSE);
   assign bus.busy      = (state != IDLE);
   assign bus.remaining = remaining;
   assign bus.done      = done;

   // remaining counts the pulse currently on add, so the last pulse is seen
   // as remaining==1 and the burst ends without a trailing gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         gap_len   <= '0;
         gap_cnt   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  gap_len <= bus.req_gap;
                  if (bus.req_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= PULSE;
                     remaining <= bus.req_count;
                  end
               end
            end

            PULSE: begin
               if (bus.abort) begin
                  state     <= IDLE;
                  remaining <= '0;
                  gap_cnt   <= '0;
               end else if (remaining == Bits'(1)) begin
                  state     <= IDLE;
                  remaining <= '0;
                  done      <= 1'b1;
               end else begin
                  remaining <= remaining - Bits'(1);
                  if (gap_len != '0) begin
                     state   <= GAP;
                     gap_cnt <= gap_len;
                  end
               end
            end

            GAP: begin
               if (bus.abort) begin
                  state     <= IDLE;
                  remaining <= '0;
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt - GapBits'(1);
                  if (gap_cnt == GapBits'(1)) begin
                     state <= PULSE;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               remaining <= '0;
               gap_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/add_pulse_gen.md
Name: add_pulse_gen

Overview:
Transmit side of the single-bit "add" increment interface consumed by the team's 8-bit counter blocks. It accepts a burst request (pulse count plus inter-pulse gap) over a valid/ready handshake. It then emits exactly that many one-cycle add pulses, separated by the requested number of idle cycles, and signals completion with a one-cycle done strobe. It sits between a control/test sequencer and any counter's add input.

Parameters:
Bits, 8, width of req_count and remaining; max burst = 2^Bits-1 pulses
GapBits, 4, width of req_gap; max gap = 2^GapBits-1 idle cycles

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  burst request valid
req_ready  output  1  block can accept a request
req_count  input  Bits  number of add pulses in the burst
req_gap  input  GapBits  idle cycles inserted between consecutive pulses
abort  input  1  synchronous cancel of the active burst
add  output  1  increment pulse to downstream counter (registered)
busy  output  1  burst in progress
remaining  output  Bits  pulses not yet completed (includes a pulse currently on add)
done  output  1  one-cycle strobe: burst completed normally (registered)

Behaviour:
- Reset (async, immediate, no clock needed): state IDLE; add=0, busy=0, done=0, remaining=0, internal gap counter=0. req_ready=0 while reset is asserted.
- States: IDLE, PULSE, GAP. add = (state==PULSE). busy = (state!=IDLE). req_ready = (state==IDLE) && !reset, combinational from state.
- Accept occurs on a rising edge with req_valid && req_ready. req_count and req_gap are latched at that edge. req_valid while busy is ignored and does not stall.
- IDLE, accept, req_count==0: stay IDLE, remaining stays 0, done=1 the next cycle. No add pulses.
- IDLE, accept, req_count!=0: go to PULSE; remaining<=req_count. add is high the cycle after accept (latency 1).
- PULSE, remaining==1: go to IDLE; remaining<=0; done<=1. No trailing gap after the last pulse.
- PULSE, remaining>1: remaining<=remaining-1. If latched gap==0, stay in PULSE (back-to-back pulses). Otherwise go to GAP with gap counter<=latched gap.
- GAP: gap counter decrements each edge. When gap counter==1, go to PULSE. Exactly `gap` idle cycles separate pulses.
- done is high for exactly one cycle. req_ready is already 1 in the done cycle, so a new request may be accepted then. A burst accepted in the done cycle begins its add pulse on the next cycle.
- abort in PULSE or GAP: next edge goes to IDLE; add=0, busy=0, remaining=0, gap counter=0; done is NOT asserted. If abort coincides with the last pulse edge, abort wins and there is no done.
- abort in IDLE has no effect. A concurrent accept proceeds normally.
- Arithmetic: remaining and gap counter are unsigned, decrement only, and never underflow; the 0 value is not reachable in PULSE/GAP.
- Total add-high cycles per completed burst == req_count exactly. Burst length in cycles = count + (count-1)*gap.

Test Plan:
- req_count=3, req_gap=0 accepted at edge 0 -> add=1 in cycles 1,2,3; remaining 3,2,1; done=1 in cycle 4 only; req_ready=1 in cycle 4.
- req_count=2, req_gap=2 -> add=1 in cycles 1 and 4, add=0 in cycles 2-3; done=1 in cycle 5; busy=1 in cycles 1-4.
- req_count=0 -> add never asserts; done=1 in cycle 1; busy stays 0.
- req_count=255, req_gap=0, add driving an 8-bit counter from 0 -> 255 consecutive add cycles; counter total=255 after done; req_valid pulses during the burst are ignored.
- req_count=5, req_gap=3, abort asserted during the first GAP cycle -> next cycle add=0, busy=0, remaining=0, done never asserts; downstream counter shows 1.
- Async reset asserted mid-PULSE between clock edges -> add, busy, remaining, done drop to 0 immediately. After release, a req_count=1 request yields a single add pulse and then done.
